riscv_instr_mem_responder: RTL and testbench



---
 rtl/riscv_instr_mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_riscv_instr_mem_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_instr_mem_responder.sv
// -----------------------------------------------------------------------------
// riscv_instr_mem_responder
//
// Memory-side responder for the instruction fetch port (req/gnt/rvalid/rdata).
// A word array answers granted fetches through a fixed-latency, in-order
// response pipeline. The number of granted-but-unanswered requests is capped,
// and grants can be suppressed externally to inject wait states.
//
// Parameters:
//   RDATA_WIDTH      response width, 32 or 128
//   DEPTH            number of RDATA_WIDTH-wide words
//   BASE_ADDR        byte address of word 0 (aligned to RDATA_WIDTH/8)
//   LATENCY          cycles from grant edge to rvalid, 1..8
//   MAX_OUTSTANDING  granted-but-unanswered requests allowed, 1..8
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   instr_req_i       fetch request
//   instr_addr_i      fetch byte address, sampled in the grant cycle
//   instr_gnt_o       request accepted this cycle (combinational)
//   instr_rvalid_o    response valid (one cycle per grant, in grant order)
//   instr_rdata_o     response data, holds its value while rvalid is low
//   stall_i           suppress grant this cycle
//   wr_en_i/wr_addr_i/wr_data_i  preload write port
//   err_o             sticky: a granted address was out of range
//   outstanding_o     current outstanding count
//
// Optional feature (macro INSTR_MEM_PERF_CNT_EN):
//   perf_gnt_cnt_o    free-running count of grants
//   perf_wait_cnt_o   free-running count of cycles with req high and no grant
// -----------------------------------------------------------------------------
module riscv_instr_mem_responder #(
  parameter int unsigned RDATA_WIDTH     = 32,
  parameter int unsigned DEPTH           = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_req_i,
  input  logic [31:0]            instr_addr_i,
  output logic                   instr_gnt_o,
  output logic                   instr_rvalid_o,
  output logic [RDATA_WIDTH-1:0] instr_rdata_o,
  input  logic                   stall_i,
  input  logic                   wr_en_i,
  input  logic [31:0]            wr_addr_i,
  input  logic [RDATA_WIDTH-1:0] wr_data_i,
  output logic                   err_o,
  output logic [3:0]             outstanding_o
`ifdef INSTR_MEM_PERF_CNT_EN
  ,
  output logic [31:0]            perf_gnt_cnt_o,
  output logic [31:0]            perf_wait_cnt_o
`endif
);

  localparam int unsigned BYTES    = RDATA_WIDTH / 8;
  localparam int unsigned OFF_BITS = $clog2(BYTES);
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Window size in bytes, computed in 64 bits so a large DEPTH cannot wrap.
  localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'(BYTES);

  typedef struct packed {
    logic             valid;
    logic             oor;
    logic [IDX_W-1:0] idx;
  } stage_t;

  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ({32'b0, off} < SPAN);
  endfunction

  // Offset bits below the word size are dropped.
  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> OFF_BITS);
  endfunction

  logic [RDATA_WIDTH-1:0] mem [DEPTH];
  logic [3:0]             outstanding_q;
  logic                   rvalid_q;
  logic [RDATA_WIDTH-1:0] rdata_q;
  logic                   err_q;
  stage_t                 grant_stage;
  stage_t                 final_stage;

  // No same-cycle bypass: a full counter blocks the grant even while the
  // oldest response is being returned.
  assign instr_gnt_o = instr_req_i & ~stall_i & ~rst &
                       (outstanding_q < 4'(MAX_OUTSTANDING));

  // NOTE: always_comb assigns every field before anything can depend on it,
  // so no path leaves a value held and no latch is inferred.
  always_comb begin
    grant_stage       = '0;
    grant_stage.valid = instr_gnt_o;
    grant_stage.oor   = ~in_range(instr_addr_i);
    grant_stage.idx   = word_idx(instr_addr_i);
  end

  // The last pipeline stage is the one that reads the array, so with
  // LATENCY=1 the grant information feeds the read directly.
  if (LATENCY == 1) begin : g_no_pipe
    assign final_stage = grant_stage;
  end else begin : g_pipe
    stage_t pipe_q [LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= grant_stage;
        for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign final_stage = pipe_q[LATENCY-2];
  end

  // NOTE: the array has no reset term; clearing it would force a register
  // implementation instead of block RAM, and preload fills it anyway.
  always_ff @(posedge clk) begin
    if (wr_en_i && in_range(wr_addr_i)) mem[word_idx(wr_addr_i)] <= wr_data_i;
  end

  // NOTE: non-blocking assignments here mean the read below sees the array
  // contents from before any write on the same edge (read-before-write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= final_stage.valid;
      if (final_stage.valid) begin
        rdata_q <= final_stage.oor ? '0 : mem[final_stage.idx];
        if (final_stage.oor) err_q <= 1'b1;
      end
    end
  end

  // Grant and response in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
    end else begin
      case ({instr_gnt_o, rvalid_q})
        2'b10:   outstanding_q <= outstanding_q + 4'd1;
        2'b01:   outstanding_q <= outstanding_q - 4'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign instr_rvalid_o = rvalid_q;
  assign instr_rdata_o  = rdata_q;
  assign err_o          = err_q;
  assign outstanding_o  = outstanding_q;

`ifdef INSTR_MEM_PERF_CNT_EN
  logic [31:0] perf_gnt_q;
  logic [31:0] perf_wait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_gnt_q  <= '0;
      perf_wait_q <= '0;
    end else begin
      if (instr_gnt_o)                 perf_gnt_q  <= perf_gnt_q + 32'd1;
      if (instr_req_i && !instr_gnt_o) perf_wait_q <= perf_wait_q + 32'd1;
    end
  end

  assign perf_gnt_cnt_o  = perf_gnt_q;
  assign perf_wait_cnt_o = perf_wait_q;
`endif

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_riscv_instr_mem_responder
//
// Three responder instances share clock and reset:
//   u_a : 32-bit,  DEPTH=16, LATENCY=1, MAX_OUTSTANDING=2
//   u_b : 32-bit,  DEPTH=16, LATENCY=2, MAX_OUTSTANDING=2
//   u_c : 128-bit, DEPTH=8,  LATENCY=3, MAX_OUTSTANDING=1
// Per-instance monitors predict the grant from req/stall and a bench-side
// outstanding count, push the expected data of each grant to a queue, and
// pop/compare it (data and latency) when rvalid appears. Directed steps in a
// single initial block add targeted checks.
// -----------------------------------------------------------------------------
module tb_riscv_instr_mem_responder;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- instance A ----------------
  logic        a_req, a_stall, a_wr_en, a_gnt, a_rvalid, a_err;
  logic [31:0] a_addr, a_wr_addr, a_wr_data, a_rdata;
  logic [3:0]  a_out;
  // ---------------- instance B ----------------
  logic        b_req, b_stall, b_wr_en, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr, b_wr_addr, b_wr_data, b_rdata;
  logic [3:0]  b_out;
  // ---------------- instance C ----------------
  logic         c_req, c_stall, c_wr_en, c_gnt, c_rvalid, c_err;
  logic [31:0]  c_addr, c_wr_addr;
  logic [127:0] c_wr_data, c_rdata;
  logic [3:0]   c_out;
`ifdef INSTR_MEM_PERF_CNT_EN
  logic [31:0] a_pg, a_pw, b_pg, b_pw, c_pg, c_pw;
`endif

  riscv_instr_mem_responder #(.RDATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h0),
    .LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
    .clk(clk), .rst(rst), .instr_req_i(a_req), .instr_addr_i(a_addr),
    .instr_gnt_o(a_gnt), .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata),
    .stall_i(a_stall), .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr),
    .wr_data_i(a_wr_data), .err_o(a_err), .outstanding_o(a_out)
`ifdef INSTR_MEM_PERF_CNT_EN
    , .perf_gnt_cnt_o(a_pg), .perf_wait_cnt_o(a_pw)
`endif
  );

  riscv_instr_mem_responder #(.RDATA_WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h0),
    .LATENCY(2), .MAX_OUTSTANDING(2)) u_b (
    .clk(clk), .rst(rst), .instr_req_i(b_req), .instr_addr_i(b_addr),
    .instr_gnt_o(b_gnt), .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata),
    .stall_i(b_stall), .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr),
    .wr_data_i(b_wr_data), .err_o(b_err), .outstanding_o(b_out)
`ifdef INSTR_MEM_PERF_CNT_EN
    , .perf_gnt_cnt_o(b_pg), .perf_wait_cnt_o(b_pw)
`endif
  );

  riscv_instr_mem_responder #(.RDATA_WIDTH(128), .DEPTH(8), .BASE_ADDR(32'h0),
    .LATENCY(3), .MAX_OUTSTANDING(1)) u_c (
    .clk(clk), .rst(rst), .instr_req_i(c_req), .instr_addr_i(c_addr),
    .instr_gnt_o(c_gnt), .instr_rvalid_o(c_rvalid), .instr_rdata_o(c_rdata),
    .stall_i(c_stall), .wr_en_i(c_wr_en), .wr_addr_i(c_wr_addr),
    .wr_data_i(c_wr_data), .err_o(c_err), .outstanding_o(c_out)
`ifdef INSTR_MEM_PERF_CNT_EN
    , .perf_gnt_cnt_o(c_pg), .perf_wait_cnt_o(c_pw)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference memories and scoreboards ----------------
  logic [31:0]  ma [16];
  logic [31:0]  mb [16];
  logic [127:0] mc [8];
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int   out_a = 0, out_b = 0, out_c = 0;
  int   max_out_b = 0, max_out_c = 0;

  always @(negedge clk) begin
    if (!rst) begin
      check("a_gnt", a_gnt, a_req & ~a_stall & (out_a < 2));
      check("a_outstanding", a_out, out_a);
      if (a_rvalid) begin
        if (qa.size() == 0) check("a_unexpected_rvalid", a_rvalid, 1'b0);
        else begin
          ea = qa.pop_front();
          check("a_rdata", a_rdata, ea.data);
          check("a_latency", cyc, ea.cyc + 1);
        end
      end
      if (a_gnt) begin
        ea.data = (a_addr < 64) ? 128'(ma[a_addr >> 2]) : '0;
        ea.cyc  = cyc;
        qa.push_back(ea);
      end
      out_a = out_a + int'(a_gnt) - int'(a_rvalid);
      // Model the write after the grant lookup: reads see pre-write data.
      if (a_wr_en && a_wr_addr < 64) ma[a_wr_addr >> 2] = a_wr_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("b_gnt", b_gnt, b_req & ~b_stall & (out_b < 2));
      check("b_outstanding", b_out, out_b);
      if (b_rvalid) begin
        if (qb.size() == 0) check("b_unexpected_rvalid", b_rvalid, 1'b0);
        else begin
          eb = qb.pop_front();
          check("b_rdata", b_rdata, eb.data);
          check("b_latency", cyc, eb.cyc + 2);
        end
      end
      if (b_gnt) begin
        eb.data = (b_addr < 64) ? 128'(mb[b_addr >> 2]) : '0;
        eb.cyc  = cyc;
        qb.push_back(eb);
      end
      out_b = out_b + int'(b_gnt) - int'(b_rvalid);
      if (int'(b_out) > max_out_b) max_out_b = int'(b_out);
      if (b_wr_en && b_wr_addr < 64) mb[b_wr_addr >> 2] = b_wr_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("c_gnt", c_gnt, c_req & ~c_stall & (out_c < 1));
      check("c_outstanding", c_out, out_c);
      if (c_rvalid) begin
        if (qc.size() == 0) check("c_unexpected_rvalid", c_rvalid, 1'b0);
        else begin
          ec = qc.pop_front();
          check("c_rdata", c_rdata, ec.data);
          check("c_latency", cyc, ec.cyc + 3);
        end
      end
      if (c_gnt) begin
        ec.data = (c_addr < 128) ? mc[c_addr >> 4] : '0;
        ec.cyc  = cyc;
        qc.push_back(ec);
      end
      out_c = out_c + int'(c_gnt) - int'(c_rvalid);
      if (int'(c_out) > max_out_c) max_out_c = int'(c_out);
      if (c_wr_en && c_wr_addr < 128) mc[c_wr_addr >> 4] = c_wr_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int g, last_cyc, k;
`ifdef INSTR_MEM_PERF_CNT_EN
  logic [31:0] w0, p0;
`endif

  initial begin
    rst = 1'b1;
    {a_req, a_stall, a_wr_en, b_req, b_stall, b_wr_en} = '0;
    {c_req, c_stall, c_wr_en} = '0;
    {a_addr, a_wr_addr, a_wr_data, b_addr, b_wr_addr, b_wr_data} = '0;
    c_addr = '0; c_wr_addr = '0; c_wr_data = '0;
    a_req = 1'b1;  // grant must stay low while reset is high

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_gnt", a_gnt, 1'b0);
    check("rst_a_rvalid", a_rvalid, 1'b0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_a_err", a_err, 1'b0);
    check("rst_a_out", a_out, 4'd0);
    check("rst_b_rvalid", b_rvalid, 1'b0);
    check("rst_c_rdata", c_rdata, 128'h0);
    check("rst_c_out", c_out, 4'd0);

    tick();
    rst   = 1'b0;
    a_req = 1'b0;

    // Preload all three memories.
    for (int i = 0; i < 16; i++) begin
      a_wr_en = 1'b1; a_wr_addr = 32'(i * 4);
      a_wr_data = (i == 0) ? 32'h0000_0013 : 32'h1000_0000 + 32'(i);
      b_wr_en = 1'b1; b_wr_addr = 32'(i * 4);
      b_wr_data = 32'h2000_0000 + 32'(i * 17);
      c_wr_en = (i < 8); c_wr_addr = 32'(i * 16);
      c_wr_data = (i == 1) ? 128'h0123_4567_89ab_cdef_0013_0001_0002_0003
                           : {4{32'hC000_0000 + 32'(i)}};
      tick();
    end
    // Out-of-range write: must be dropped, not alias onto word 0.
    a_wr_addr = 32'd64; a_wr_data = 32'hFFFF_FFFF;
    b_wr_en = 1'b0; c_wr_en = 1'b0;
    tick();
    a_wr_en = 1'b0;
    tick();

    // Single fetch, LATENCY=1.
    a_req = 1'b1; a_addr = 32'h0;
    @(negedge clk);
    check("t1_gnt", a_gnt, 1'b1);
    tick();
    a_req = 1'b0;
    @(negedge clk);
    check("t1_rvalid", a_rvalid, 1'b1);
    check("t1_rdata", a_rdata, 32'h0000_0013);
    check("t1_err_after_oor_write", a_err, 1'b0);
    tick();
    @(negedge clk);
    check("t1_out_zero", a_out, 4'd0);
    check("t1_rvalid_low", a_rvalid, 1'b0);
    check("t1_rdata_hold", a_rdata, 32'h0000_0013);
    tick();

    // Stall for 3 cycles with req high, then an out-of-range fetch.
    a_req = 1'b1; a_stall = 1'b1; a_addr = 32'h4;
`ifdef INSTR_MEM_PERF_CNT_EN
    w0 = a_pw; p0 = a_pg;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_gnt_low", a_gnt, 1'b0);
      tick();
    end
`ifdef INSTR_MEM_PERF_CNT_EN
    check("perf_wait_3", a_pw, w0 + 32'd3);
`endif
    a_stall = 1'b0; a_addr = 32'd64;  // BASE_ADDR + DEPTH*4
    @(negedge clk);
    check("oor_gnt", a_gnt, 1'b1);
    check("oor_err_before", a_err, 1'b0);
    tick();
    a_req = 1'b0;
    @(negedge clk);
    check("oor_rvalid", a_rvalid, 1'b1);
    check("oor_rdata_zero", a_rdata, 32'h0);
    check("oor_err_set", a_err, 1'b1);
`ifdef INSTR_MEM_PERF_CNT_EN
    check("perf_gnt_1", a_pg, p0 + 32'd1);
`endif
    repeat (3) tick();
    @(negedge clk);
    check("oor_err_sticky", a_err, 1'b1);
    tick();

    // Same-cycle write and read of word 0: old data, then new data.
    a_req = 1'b1; a_addr = 32'h0;
    a_wr_en = 1'b1; a_wr_addr = 32'h0; a_wr_data = 32'hDEAD_BEEF;
    tick();
    a_wr_en = 1'b0;
    @(negedge clk);
    check("coll_rvalid", a_rvalid, 1'b1);
    check("coll_old_data", a_rdata, 32'h0000_0013);
    tick();
    a_req = 1'b0;
    @(negedge clk);
    check("coll_new_data", a_rdata, 32'hDEAD_BEEF);
    tick();

    // Streaming on B: hold req, advance the address on each grant.
    k = 0;
    for (int n = 0; n < 20 && k < 4; n++) begin
      b_req = 1'b1; b_addr = 32'(k * 4);
      @(negedge clk);
      if (b_gnt) k++;
      tick();
    end
    b_req = 1'b0;
    check("stream_grants", k, 4);
    repeat (4) tick();
    check("stream_out_max", max_out_b <= 2, 1'b1);

    // 128-bit fetch of word 1 via byte address 0x14.
    c_req = 1'b1; c_addr = 32'h14;
    @(negedge clk);
    check("w128_gnt", c_gnt, 1'b1);
    tick();
    c_req = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("w128_rvalid", c_rvalid, 1'b1);
    check("w128_rdata", c_rdata, 128'h0123_4567_89ab_cdef_0013_0001_0002_0003);
    repeat (2) tick();

    // Limit on C: with no bypass the next grant follows LATENCY+1 cycles later.
    g = 0; last_cyc = 0;
    c_req = 1'b1;
    for (int n = 0; n < 16; n++) begin
      c_addr = (g == 0) ? 32'h14 : 32'((g % 8) * 16);
      @(negedge clk);
      if (c_gnt) begin
        if (g > 0) check("limit_gnt_period", cyc - last_cyc, 4);
        last_cyc = cyc;
        g++;
      end
      tick();
    end
    c_req = 1'b0;
    check("limit_grants", g, 4);
    check("limit_out_max", max_out_c <= 1, 1'b1);
    repeat (5) tick();

    // Reset with two requests in flight on B.
    b_req = 1'b1; b_addr = 32'h8;
    @(negedge clk);
    check("rstmid_gnt0", b_gnt, 1'b1);
    tick();
    b_addr = 32'hC;
    @(negedge clk);
    check("rstmid_gnt1", b_gnt, 1'b1);
    tick();
    rst = 1'b1;
    b_addr = 32'h0;  // req stays high across reset
    qa.delete(); qb.delete(); qc.delete();
    out_a = 0; out_b = 0; out_c = 0;
    @(negedge clk);
    check("rstmid_gnt_low", b_gnt, 1'b0);
    check("rstmid_rvalid", b_rvalid, 1'b0);
    check("rstmid_out", b_out, 4'd0);
    check("rstmid_a_err_cleared", a_err, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("first_gnt_after_rst", b_gnt, 1'b1);
    tick();
    b_req = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    check("drain_c", qc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
